// File: rtl/uart_wb_ctrl_pkg.sv
// Shared definitions for the Wishbone UART controller: register offsets,
// STATUS bit positions and the TX/RX state encodings.
package uart_wb_ctrl_pkg;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;

  localparam int ST_TX_READY  = 0;
  localparam int ST_RX_VALID  = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_TX_BUSY   = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter for bit timing. tick is high while the count is zero;
// restart reloads, so a load of N-1 gives a tick N cycles after the reload.
module uart_baud_cnt #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         restart,
  input  logic [W-1:0] load,
  output logic         tick
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (restart)      cnt <= load;
    else if (cnt != '0)    cnt <= cnt - W'(1);
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_wb_ctrl.sv
// Wishbone slave UART: double-buffered 8N1 transmitter, single-buffered
// receiver with overrun/framing flags and a level interrupt on rx_valid.
module uart_wb_ctrl
  import uart_wb_ctrl_pkg::*;
#(
  parameter int CLK_FREQ = 11059200,
  parameter int BAUD     = 115200,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_addr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_ack_o,
  output logic              com_TxD,
  input  logic              com_RxD,
  output logic              rx_int_o
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 1);

  tx_state_e tx_state, tx_next;
  rx_state_e rx_state, rx_next;
  logic [7:0] tx_hold, tx_shift, rx_shift, rx_byte;
  logic [2:0] tx_bit_idx, rx_bit_idx;
  logic       hold_full, rx_valid, overrun, frame_err;
  logic       tx_restart, tx_tick, tx_load, tx_shift_en;
  logic       rx_restart, rx_tick, rx_sample, rx_clr_idx, stop_ok, stop_bad;
  logic [CNT_W-1:0] rx_load;
  logic       rx_meta, rx_s, rx_prev, rx_fall;
  logic       req, wr_push, data_rd, status_rd;
  logic [1:0] reg_sel;
  logic [4:0] status;
  logic [DATA_W-1:0] rd_data;
  logic       unused_bits;

  // Wishbone: a request is cyc & stb while ack is low; ack follows one cycle
  // later for exactly one cycle carrying read data; side effects occur in the request cycle.
  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign reg_sel   = wb_addr_i[3:2];
  assign wr_push   = req & wb_we_i & wb_sel_i[0] & (reg_sel == UART_DATA) & ~hold_full;
  assign data_rd   = req & ~wb_we_i & (reg_sel == UART_DATA);
  assign status_rd = req & ~wb_we_i & (reg_sel == UART_STATUS);
  assign status    = {tx_state != TX_IDLE, frame_err, overrun, rx_valid, ~hold_full};
  assign rx_int_o  = rx_valid;
  assign unused_bits = ^{wb_addr_i[31:4], wb_addr_i[1:0], wb_sel_i[3:1], wb_data_i[DATA_W-1:8]};

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      UART_DATA:   rd_data = DATA_W'(rx_byte);
      UART_STATUS: rd_data = DATA_W'(status);
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_o  <= 1'b0;
      wb_data_o <= '0;
    end else begin
      wb_ack_o  <= req;
      wb_data_o <= (req & ~wb_we_i) ? rd_data : '0;
    end
  end

  uart_baud_cnt #(.W(CNT_W)) u_tx_cnt (
    .clk(clk), .rst(rst), .restart(tx_restart), .load(BIT_LOAD), .tick(tx_tick)
  );

  always_comb begin
    tx_next     = tx_state;
    tx_restart  = 1'b0;
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;
    com_TxD     = 1'b1;
    case (tx_state)
      TX_IDLE: if (hold_full) begin
        tx_next    = TX_START;
        tx_restart = 1'b1;
        tx_load    = 1'b1;
      end
      TX_START: begin
        com_TxD = 1'b0;
        if (tx_tick) begin
          tx_next    = TX_DATA;
          tx_restart = 1'b1;
        end
      end
      TX_DATA: begin
        com_TxD = tx_shift[0];
        if (tx_tick) begin
          tx_restart  = 1'b1;
          tx_shift_en = 1'b1;
          if (tx_bit_idx == 3'd7) tx_next = TX_STOP;
        end
      end
      TX_STOP: if (tx_tick) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  // A push only happens while holding is empty and a load only while it is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state   <= TX_IDLE;
      tx_hold    <= '0;
      hold_full  <= 1'b0;
      tx_shift   <= '0;
      tx_bit_idx <= '0;
    end else begin
      tx_state <= tx_next;
      if (wr_push) begin
        tx_hold   <= wb_data_i[7:0];
        hold_full <= 1'b1;
      end else if (tx_load) begin
        hold_full <= 1'b0;
      end
      if (tx_load) begin
        tx_shift   <= tx_hold;
        tx_bit_idx <= '0;
      end else if (tx_shift_en) begin
        tx_shift   <= {1'b0, tx_shift[7:1]};
        tx_bit_idx <= tx_bit_idx + 3'd1;
      end
    end
  end

  uart_baud_cnt #(.W(CNT_W)) u_rx_cnt (
    .clk(clk), .rst(rst), .restart(rx_restart), .load(rx_load), .tick(rx_tick)
  );

  assign rx_fall = rx_prev & ~rx_s;

  always_comb begin
    rx_next    = rx_state;
    rx_restart = 1'b0;
    rx_load    = BIT_LOAD;
    rx_sample  = 1'b0;
    rx_clr_idx = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_fall) begin
        rx_next    = RX_START;
        rx_restart = 1'b1;
        rx_load    = HALF_LOAD;
      end
      RX_START: if (rx_tick) begin
        if (!rx_s) begin
          rx_next    = RX_DATA;
          rx_restart = 1'b1;
          rx_clr_idx = 1'b1;
        end else begin
          rx_next = RX_IDLE;
        end
      end
      RX_DATA: if (rx_tick) begin
        rx_restart = 1'b1;
        rx_sample  = 1'b1;
        if (rx_bit_idx == 3'd7) rx_next = RX_STOP;
      end
      RX_STOP: if (rx_tick) begin
        rx_next  = RX_IDLE;
        stop_ok  = rx_s;
        stop_bad = ~rx_s;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // Flag updates: a set from the receiver wins over a clear from the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_shift   <= '0;
      rx_bit_idx <= '0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta  <= com_RxD;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      rx_state <= rx_next;
      if (rx_clr_idx) rx_bit_idx <= '0;
      else if (rx_sample) begin
        rx_shift   <= {rx_s, rx_shift[7:1]};
        rx_bit_idx <= rx_bit_idx + 3'd1;
      end
      if (stop_ok) rx_byte <= rx_shift;
      if (stop_ok)      rx_valid <= 1'b1;
      else if (data_rd) rx_valid <= 1'b0;
      if (stop_ok && rx_valid && !data_rd) overrun <= 1'b1;
      else if (status_rd)                  overrun <= 1'b0;
      if (stop_bad)       frame_err <= 1'b1;
      else if (status_rd) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_wb_ctrl.sv
// Directed bench for uart_wb_ctrl: bus reads/writes and serial frames are
// checked against hand-computed values through expected-value queues.
module tb_uart_wb_ctrl;

  localparam int DIV = 96;
  localparam logic [31:0] A_DATA = 32'h0, A_STATUS = 32'h4, A_R2 = 32'h8, A_R3 = 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0] wb_addr_i = '0, wb_data_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic [31:0] wb_data_o;
  logic        wb_ack_o, com_TxD, rx_int_o;
  logic        com_RxD = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [7:0]  tx_exp_q[$];
  int          start_q[$];

  uart_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_addr_i(wb_addr_i), .wb_sel_i(wb_sel_i), .wb_data_i(wb_data_i),
    .wb_data_o(wb_data_o), .wb_ack_o(wb_ack_o),
    .com_TxD(com_TxD), .com_RxD(com_RxD), .rx_int_o(rx_int_o)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] sel, input logic [31:0] exp, input string name);
    int n;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_addr_i = addr; wb_sel_i = sel; wb_data_i = wdata;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_data_i = '0;
    n = 0;
    while (!wb_ack_o && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!wb_ack_o) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout_%s: no ack within 8 cycles, required ack=1", name);
    end
    @(posedge clk);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input string name);
    bus(1'b1, addr, data, 4'h1, 32'h0, name);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    bus(1'b0, addr, 32'h0, 4'hF, exp, name);
  endtask

  task automatic rx_bit(input logic v);
    #1 com_RxD = v;
    repeat (DIV) @(posedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(posedge clk);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stop);
    rx_bit(1'b1);
    rx_bit(1'b1);
  endtask

  task automatic wait_tx_empty(input int budget, input string name);
    int n;
    n = 0;
    while (tx_exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_tx_drained"}, tx_exp_q.size(), 0);
  endtask

  task automatic tx_wait(input int n, inout bit ab);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  // scoreboard: bus responses
  always @(negedge clk) begin
    logic [31:0] e;
    string       n;
    if (!rst && wb_ack_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack with data 0x%0h, required no ack", wb_data_o);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, wb_data_o, e);
      end
    end
  end

  // scoreboard: serial frames on com_TxD, sampled mid-bit
  initial begin
    logic [7:0] b;
    logic       sb, pb;
    bit         ab;
    int         st;
    forever begin
      @(negedge com_TxD);
      st = cyc_cnt;
      ab = 1'b0;
      tx_wait(DIV / 2, ab);
      sb = com_TxD;
      for (int i = 0; i < 8; i++) begin
        tx_wait(DIV, ab);
        b[i] = com_TxD;
      end
      tx_wait(DIV, ab);
      pb = com_TxD;
      if (!ab) begin
        start_q.push_back(st);
        check("tx_start_bit", {31'h0, sb}, 32'h0);
        check("tx_stop_bit", {31'h0, pb}, 32'h1);
        if (tx_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_frame: got byte 0x%0h, required no frame", b);
        end else begin
          check("tx_byte", {24'h0, b}, {24'h0, tx_exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    int gap;
    // reset
    repeat (5) @(posedge clk);
    #1;
    check("rst_txd", {31'h0, com_TxD}, 32'h1);
    check("rst_ack", {31'h0, wb_ack_o}, 32'h0);
    check("rst_data", wb_data_o, 32'h0);
    check("rst_int", {31'h0, rx_int_o}, 32'h0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("ack_idle", {31'h0, wb_ack_o}, 32'h0);
    rd(A_STATUS, 32'h01, "status_reset");

    // single TX byte, busy while shifting
    tx_exp_q.push_back(8'h55);
    wr(A_DATA, 32'h55, "wr_55");
    rd(A_STATUS, 32'h11, "status_tx_busy");
    wait_tx_empty(12 * DIV, "single");
    repeat (DIV) @(posedge clk);
    rd(A_STATUS, 32'h01, "status_tx_done");

    // back-to-back frames, third write dropped
    start_q.delete();
    tx_exp_q.push_back(8'hA5);
    tx_exp_q.push_back(8'h3C);
    wr(A_DATA, 32'hA5, "wr_a5");
    wr(A_DATA, 32'h3C, "wr_3c");
    wr(A_DATA, 32'h99, "wr_99_dropped");
    rd(A_STATUS, 32'h10, "status_hold_full");
    wait_tx_empty(25 * DIV, "b2b");
    repeat (12 * DIV) @(posedge clk);
    check("b2b_frames", start_q.size(), 2);
    if (start_q.size() >= 2) begin
      gap = start_q[1] - start_q[0];
      check("b2b_gap", {31'h0, (gap >= 10 * DIV && gap <= 10 * DIV + 1)}, 32'h1);
    end

    // ignored writes and unmapped registers
    bus(1'b1, A_DATA, 32'h77, 4'h0, 32'h0, "wr_sel0");
    wr(A_R2, 32'hAB, "wr_r2");
    rd(A_STATUS, 32'h01, "status_after_ignored");
    rd(A_R2, 32'h0, "rd_r2");
    rd(A_R3, 32'h0, "rd_r3");

    // RX single byte
    send_rx(8'hC3, 1'b1);
    check("rx_int_set", {31'h0, rx_int_o}, 32'h1);
    rd(A_DATA, 32'hC3, "rd_c3");
    rd(A_STATUS, 32'h01, "status_rx_cleared");
    check("rx_int_clr", {31'h0, rx_int_o}, 32'h0);

    // overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd(A_STATUS, 32'h07, "status_overrun");
    rd(A_STATUS, 32'h03, "status_overrun_cleared");
    rd(A_DATA, 32'h22, "rd_22");
    rd(A_STATUS, 32'h01, "status_after_22");

    // framing error keeps the earlier byte
    send_rx(8'h5A, 1'b1);
    send_rx(8'h77, 1'b0);
    rd(A_STATUS, 32'h0B, "status_frame_err");
    rd(A_DATA, 32'h5A, "rd_5a");
    rd(A_STATUS, 32'h01, "status_after_ferr");

    // glitch shorter than half a bit
    @(posedge clk);
    #1 com_RxD = 1'b0;
    repeat (DIV / 4) @(posedge clk);
    #1 com_RxD = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    rd(A_STATUS, 32'h01, "status_glitch");
    check("glitch_int", {31'h0, rx_int_o}, 32'h0);

    // reset during a TX data bit (0xF0 sends 0 in bits 0..3)
    wr(A_DATA, 32'hF0, "wr_f0");
    repeat (DIV + DIV / 2) @(posedge clk);
    #2 check("txd_data_bit0", {31'h0, com_TxD}, 32'h0);
    rst = 1'b1;
    #1;
    check("txd_async_rst", {31'h0, com_TxD}, 32'h1);
    check("ack_async_rst", {31'h0, wb_ack_o}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    rd(A_STATUS, 32'h01, "status_after_rst");
    repeat (12 * DIV) @(posedge clk);
    check("txd_idle_after_rst", {31'h0, com_TxD}, 32'h1);

    // final report
    repeat (4) @(posedge clk);
    check("bus_queue_empty", exp_q.size(), 0);
    check("tx_queue_empty", tx_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
